// File: rtl/gen_pkg.sv
// Shared types and width helpers for the generator scheduler.
package gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GAP   = 2'd1,
    HOLD  = 2'd2,
    GRANT = 2'd3
  } state_t;

  // Width of a generator index; never narrower than one bit.
  function automatic int src_w(input int n_gen);
    return (n_gen > 1) ? $clog2(n_gen) : 1;
  endfunction

  // Width of the FIFO occupancy count, which must be able to hold DEPTH itself.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through sample FIFO with a registered head word and occupancy.
module sample_fifo
  import gen_pkg::*;
#(
  parameter int W     = 10,
  parameter int DEPTH = 8,
  localparam int LVL_W = lvl_w(DEPTH)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop_ready,
  output logic             rd_valid,
  output logic [W-1:0]     rd_data,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic             do_push;
  logic             do_pop;
  logic [LVL_W-1:0] level_nxt;
  logic [W-1:0]     head_nxt;

  // A pop is only honoured when a word is present, so popping an empty FIFO is a no-op.
  assign do_pop     = rd_valid & pop_ready;
  assign do_push    = push & ((level != FULL_LVL) | do_pop);
  assign rd_ptr_inc = rd_ptr + 1'b1;

  // Next occupancy and next head word; a simultaneous push and pop keeps level unchanged.
  always_comb begin
    level_nxt = level;
    head_nxt  = rd_data;
    case ({do_push, do_pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
    if (do_pop) begin
      if (level > LVL_W'(1)) head_nxt = mem[rd_ptr_inc];
      else if (do_push)      head_nxt = push_data;
    end else if (level == '0 && do_push) begin
      head_nxt = push_data;
    end
  end

  // Pointers, occupancy and valid flag; reset empties the FIFO.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr_inc;
      level    <= level_nxt;
      rd_valid <= (level_nxt != '0);
    end
  end

  // Storage and head word carry no reset; they are qualified by rd_valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
    rd_data <= head_nxt;
  end

endmodule

// File: rtl/gen_scheduler.sv
// Round-robin grant of a shared bus to N_GEN count generators, sampling each slot into a FIFO.
module gen_scheduler
  import gen_pkg::*;
#(
  parameter int N_GEN       = 4,
  parameter int WIDTH       = 8,
  parameter int SLOT_CYCLES = 4,
  parameter int FIFO_DEPTH  = 8,
  localparam int SRC_W = src_w(N_GEN),
  localparam int LVL_W = lvl_w(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             run,
  output logic [N_GEN-1:0] gen_en,
  input  logic [WIDTH-1:0] bus,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SRC_W-1:0] out_src,
  output logic [LVL_W-1:0] level,
  output logic             busy
);

  localparam logic [7:0]       SLOT_LAST = 8'(SLOT_CYCLES - 1);
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);
  localparam logic [SRC_W-1:0] IDX_LAST  = SRC_W'(N_GEN - 1);
  localparam logic [N_GEN-1:0] EN_ONE    = N_GEN'(1);

  state_t                  state_q;
  state_t                  state_nxt;
  logic [SRC_W-1:0]        idx_q;
  logic [SRC_W-1:0]        idx_nxt;
  logic [7:0]              slot_q;
  logic [7:0]              slot_nxt;
  logic                    smp_push;
  logic [SRC_W+WIDTH-1:0]  head_word;
  logic [N_GEN-1:0]        gen_en_nxt;

  // Next-state logic; the full check is made before GRANT, so one push per slot never overflows.
  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    slot_nxt  = slot_q;
    smp_push  = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) state_nxt = GAP;
      end
      GAP, HOLD: begin
        if (!run)                  state_nxt = IDLE;
        else if (level < FULL_LVL) state_nxt = GRANT;
        else                       state_nxt = HOLD;
      end
      GRANT: begin
        if (slot_q == SLOT_LAST) begin
          smp_push  = 1'b1;
          slot_nxt  = '0;
          idx_nxt   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          state_nxt = GAP;
        end else begin
          slot_nxt = slot_q + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    gen_en_nxt = (state_nxt == GRANT) ? (EN_ONE << idx_nxt) : '0;
  end

  // FSM registers plus registered enables and busy; reset drops gen_en immediately.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= IDLE;
      idx_q   <= '0;
      slot_q  <= '0;
      gen_en  <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      idx_q   <= idx_nxt;
      slot_q  <= slot_nxt;
      gen_en  <= gen_en_nxt;
      busy    <= (state_nxt != IDLE);
    end
  end

  // The bus is captured only on the last GRANT cycle, while gen_en[idx_q] is high.
  sample_fifo #(
    .W     (SRC_W + WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .res       (res),
    .push      (smp_push),
    .push_data ({idx_q, bus}),
    .pop_ready (out_ready),
    .rd_valid  (out_valid),
    .rd_data   (head_word),
    .level     (level)
  );

  assign out_src  = head_word[WIDTH +: SRC_W];
  assign out_data = head_word[WIDTH-1:0];

endmodule

// File: tb/tb_gen_scheduler.sv
// Directed bench for gen_scheduler: round-robin, backpressure, stop, wrap, async reset, push/pop.
module tb_gen_scheduler;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: N_GEN=4, WIDTH=8, SLOT_CYCLES=4, FIFO_DEPTH=8
  logic       res, run, out_ready, out_valid, busy;
  logic [3:0] gen_en;
  wire  [7:0] bus;
  logic [7:0] out_data;
  logic [1:0] out_src;
  logic [3:0] level;

  gen_scheduler #(.N_GEN(4), .WIDTH(8), .SLOT_CYCLES(4), .FIFO_DEPTH(8)) u_dut (
    .clk(clk), .res(res), .run(run), .gen_en(gen_en), .bus(bus),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .level(level), .busy(busy)
  );

  // Wrap instance: N_GEN=2, SLOT_CYCLES=1
  logic       res_w, run_w, out_ready_w, out_valid_w, busy_w;
  logic [1:0] gen_en_w;
  wire  [7:0] bus_w;
  logic [7:0] out_data_w;
  logic [0:0] out_src_w;
  logic [3:0] level_w;

  gen_scheduler #(.N_GEN(2), .WIDTH(8), .SLOT_CYCLES(1), .FIFO_DEPTH(8)) u_dut_w (
    .clk(clk), .res(res_w), .run(run_w), .gen_en(gen_en_w), .bus(bus_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w), .out_data(out_data_w),
    .out_src(out_src_w), .level(level_w), .busy(busy_w)
  );

  // Generator models: show the count while enabled, advance once per enabled cycle.
  logic       gen_clr, gen_clr_w;
  logic [7:0] cnt_a [4];
  logic [7:0] cnt_w [2];
  logic [7:0] val_a, val_w;

  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (gen_clr) cnt_a[i] <= 8'd0;
      else if (gen_en[i]) cnt_a[i] <= cnt_a[i] + 8'd1;

  always @(posedge clk)
    for (int j = 0; j < 2; j++)
      if (gen_clr_w) cnt_w[j] <= 8'd200;
      else if (gen_en_w[j]) cnt_w[j] <= cnt_w[j] + 8'd1;

  always_comb begin
    val_a = 8'd0;
    for (int k = 0; k < 4; k++) if (gen_en[k]) val_a = cnt_a[k];
  end
  always_comb begin
    val_w = 8'd0;
    for (int m = 0; m < 2; m++) if (gen_en_w[m]) val_w = cnt_w[m];
  end

  assign bus   = (|gen_en)   ? val_a : 8'bzzzz_zzzz;
  assign bus_w = (|gen_en_w) ? val_w : 8'bzzzz_zzzz;

  // Checking
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Popped (src,data) words of the main instance, recorded at the negedge before the pop edge.
  logic [9:0] q [$];

  task automatic check_q(input string tag, input int i, input int src, input int data);
    if (i < q.size()) check(tag, 32'(q[i]), 32'((src << 8) | data));
    else check({tag, "_missing"}, 32'(q.size()), 32'(i + 1));
  endtask

  // Bus-discipline monitor for the main instance
  int         multi_err = 0, gap_err = 0, gaplen_err = 0, slotlen_err = 0;
  int         zr = 0, run_len = 0;
  bit         seen = 0, rr_mode = 0;
  logic [3:0] prev_en = 4'd0;

  always @(negedge clk) begin
    if ($countones(gen_en) > 1) multi_err++;
    if (gen_en != 4'd0 && prev_en != 4'd0 && gen_en != prev_en) gap_err++;
    if (rr_mode) begin
      if (gen_en == 4'd0) begin
        if (prev_en != 4'd0 && run_len != 4) slotlen_err++;
        zr++;
      end else begin
        if (prev_en == 4'd0) begin
          if (seen && zr != 1) gaplen_err++;
          run_len = 0;
        end
        run_len++;
        seen = 1;
        zr = 0;
      end
    end else begin
      seen = 0;
      zr = 0;
      run_len = 0;
    end
    prev_en = gen_en;
    if (out_valid && out_ready) q.push_back({out_src, out_data});
  end

  // Wrap monitor: per-source expected value advances by one each round, modulo 256.
  logic [7:0] exp_w [2];
  logic [0:0] exp_src_w;
  int         wrap_err = 0, wrap_cnt = 0, wrap_zero = 0;

  always @(negedge clk) begin
    if (out_valid_w && out_ready_w) begin
      if (out_src_w != exp_src_w) wrap_err++;
      if (out_data_w != exp_w[out_src_w]) wrap_err++;
      if (out_data_w == 8'd0) wrap_zero++;
      exp_w[out_src_w] = exp_w[out_src_w] + 8'd1;
      exp_src_w = ~exp_src_w;
      wrap_cnt++;
    end
  end

  task automatic do_reset();
    res = 1'b0;
    gen_clr = 1'b1;
    run = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 gen_clr = 1'b0;
    @(negedge clk);
    res = 1'b1;
    q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    res = 1'b0; run = 1'b0; out_ready = 1'b0; gen_clr = 1'b1;
    res_w = 1'b0; run_w = 1'b0; out_ready_w = 1'b0; gen_clr_w = 1'b1;
    exp_w[0] = 8'd200; exp_w[1] = 8'd200; exp_src_w = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gen_en", 32'(gen_en), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Round-robin
    do_reset();
    out_ready = 1'b1;
    rr_mode = 1'b1;
    run = 1'b1;
    n = 0;
    while (q.size() < 6 && n < 300) begin @(negedge clk); n++; end
    check("rr_timeout", 32'(n < 300), 32'd1);
    rr_mode = 1'b0;
    run = 1'b0;
    check_q("rr0", 0, 0, 3);
    check_q("rr1", 1, 1, 3);
    check_q("rr2", 2, 2, 3);
    check_q("rr3", 3, 3, 3);
    check_q("rr4", 4, 0, 7);
    check_q("rr5", 5, 1, 7);
    check("rr_gap_len", 32'(gaplen_err), 32'd0);
    check("rr_slot_len", 32'(slotlen_err), 32'd0);
    n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    check("rr_idle", 32'(busy), 32'd0);

    // Backpressure
    do_reset();
    run = 1'b1;
    n = 0;
    while (level != 4'd8 && n < 300) begin @(negedge clk); n++; end
    check("bp_fill", 32'(level), 32'd8);
    repeat (10) @(negedge clk);
    check("bp_hold_en", 32'(gen_en), 32'd0);
    check("bp_hold_busy", 32'(busy), 32'd1);
    check("bp_hold_lvl", 32'(level), 32'd8);
    check("bp_hold_head", 32'({out_valid, out_src, out_data}), 32'h403);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp_pop_lvl", 32'(level), 32'd7);
    n = 0;
    while (gen_en == 4'd0 && n < 10) begin @(negedge clk); n++; end
    check("bp_regrant", 32'(gen_en), 32'd1);
    n = 0;
    while (level != 4'd8 && n < 20) begin @(negedge clk); n++; end
    run = 1'b0;
    check("bp_refill", 32'(level), 32'd8);
    out_ready = 1'b1;
    n = 0;
    while ((busy || level != 4'd0) && n < 50) begin @(negedge clk); n++; end
    check("bp_drain", 32'(level), 32'd0);
    check("bp_count", 32'(q.size()), 32'd9);
    check_q("bp0", 0, 0, 3);
    check_q("bp4", 4, 0, 7);
    check_q("bp7", 7, 3, 7);
    check_q("bp8", 8, 0, 11);

    // Stop mid-slot
    do_reset();
    out_ready = 1'b1;
    run = 1'b1;
    n = 0;
    while (gen_en != 4'b0100 && n < 100) begin @(negedge clk); n++; end
    check("stop_slot2", 32'(gen_en), 32'b0100);
    @(posedge clk); #1 run = 1'b0;
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_en", 32'(gen_en), 32'd0);
    check_q("stop_s2", 2, 2, 3);
    run = 1'b1;
    n = 0;
    while (gen_en == 4'd0 && n < 10) begin @(negedge clk); n++; end
    check("stop_resume", 32'(gen_en), 32'b1000);
    n = 0;
    while (q.size() < 4 && n < 20) begin @(negedge clk); n++; end
    run = 1'b0;
    check_q("stop_s3", 3, 3, 3);
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end

    // Async reset mid-grant
    do_reset();
    run = 1'b1;
    n = 0;
    while (!(level >= 4'd2 && gen_en != 4'd0) && n < 100) begin @(negedge clk); n++; end
    check("ar_setup", 32'(level >= 4'd2 && gen_en != 4'd0), 32'd1);
    #2 res = 1'b0;
    #1;
    check("ar_en", 32'(gen_en), 32'd0);
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_level", 32'(level), 32'd0);
    @(posedge clk);
    @(negedge clk);
    res = 1'b1;
    n = 0;
    while (gen_en == 4'd0 && n < 10) begin @(negedge clk); n++; end
    check("ar_first", 32'(gen_en), 32'd1);
    run = 1'b0;
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end

    // Simultaneous push and pop at level 1
    do_reset();
    run = 1'b1;
    n = 0;
    while (gen_en != 4'b0010 && n < 100) begin @(negedge clk); n++; end
    check("pp_level1", 32'(level), 32'd1);
    repeat (3) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    run = 1'b0;
    @(negedge clk);
    check("pp_level", 32'(level), 32'd1);
    check("pp_head", 32'({out_valid, out_src, out_data}), 32'h503);
    check("pp_popped", 32'(q.size()), 32'd1);
    check_q("pp_first", 0, 0, 3);
    check("bus_multi_hot", 32'(multi_err), 32'd0);
    check("bus_no_gap", 32'(gap_err), 32'd0);

    // Wrap on the second instance
    repeat (2) @(posedge clk);
    #1 gen_clr_w = 1'b0;
    @(negedge clk);
    res_w = 1'b1;
    out_ready_w = 1'b1;
    run_w = 1'b1;
    repeat (600) @(negedge clk);
    run_w = 1'b0;
    n = 0;
    while ((busy_w || level_w != 4'd0) && n < 30) begin @(negedge clk); n++; end
    check("wrap_drain", 32'(level_w), 32'd0);
    check("wrap_seq", 32'(wrap_err), 32'd0);
    check("wrap_zero", 32'(wrap_zero), 32'd2);
    check("wrap_count", 32'(wrap_cnt >= 290), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gen_scheduler.md
Name: gen_scheduler

Overview:
- Time-multiplexes N_GEN count generators onto one shared tristate bus, with one counter per generator.
- Drives each generator's en with a one-hot, round-robin grant, so exactly one generator drives the bus at a time.
- Samples the bus at the end of each grant slot and pushes {source id, value} into an internal FIFO.
- The FIFO drains through a valid/ready stream to the downstream consumer.

Parameters:
- N_GEN, 4: number of generators on the bus (2..16).
- WIDTH, 8: bus and sample data width.
- SLOT_CYCLES, 4: cycles en is held high per grant (1..255).
- FIFO_DEPTH, 8: sample FIFO entries (power of two, >=2).

Ports:
- clk  in  1: single clock; all state on posedge.
- res  in  1: reset, asynchronous, active-low.
- run  in  1: level; 1 = keep scheduling, 0 = stop after the current slot.
- gen_en  out  N_GEN: one-hot-or-zero enables, one bit per generator.
- bus  in  WIDTH: shared tristate bus, driven by the enabled generator.
- out_valid  out  1: FIFO head valid.
- out_ready  in  1: consumer accepts the head.
- out_data  out  WIDTH: sampled bus value.
- out_src  out  $clog2(N_GEN): index of the generator that produced out_data.
- level  out  $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- busy  out  1: high in any state except IDLE.

Behaviour:
- Reset (res=0, async): gen_en=0, out_valid=0, level=0, FIFO pointers=0, idx=0, state=IDLE, slot counter=0. All outputs are registered.
- FSM state IDLE: gen_en=0. Moves to GAP when run=1.
- FSM state GAP: exactly one cycle with gen_en=0, so two generators never drive the bus in the same cycle.
  - Next state is GRANT if level < FIFO_DEPTH.
  - Otherwise next state is HOLD.
  - If run=0, next state is IDLE.
- FSM state HOLD: gen_en=0; waits until level < FIFO_DEPTH, then goes to GRANT. If run=0, goes to IDLE.
- FSM state GRANT: gen_en = 1<<idx, held for exactly SLOT_CYCLES cycles.
  - On the last GRANT cycle (slot counter == SLOT_CYCLES-1), bus is registered into the FIFO tail with src=idx.
  - idx advances modulo N_GEN (N_GEN-1 -> 0).
  - Next state is GAP.
  - The full check happens before GRANT is entered, and there is only one push per slot, so a push never overflows.
- run deasserted mid-GRANT: the slot completes and its sample is pushed, then the FSM goes to IDLE via GAP.
- The bus is sampled only while the matching gen_en bit is high. A floating/Z bus is never captured.
- Generator timing: a generator shows value v in the first granted cycle and v+k in cycle k. The captured value is therefore v+SLOT_CYCLES-1.
- FIFO behaviour:
  - First-word-fall-through: out_valid asserts the cycle after the push.
  - A pop occurs on out_valid & out_ready.
  - A simultaneous push and pop leaves level unchanged.
  - A pop when empty is ignored.
  - out_data and out_src hold stable while out_valid=1 and out_ready=0.
- busy = (state != IDLE).
- Reset mid-operation: gen_en drops asynchronously and queued samples are discarded. Generator counters are not reset by this block.

Decomposition:
- Shared package gen_pkg:
  - state enum {IDLE, GAP, HOLD, GRANT};
  - the SRC_W and LVL_W width helper functions.
- Sub-module sample_fifo (WIDTH+SRC_W wide, FIFO_DEPTH deep, async active-low res, FWFT, level output).

Test Plan:
- Round-robin: N_GEN=4, SLOT_CYCLES=4, generators reset to 0, run=1, out_ready=1.
  - Outputs (src,data) = (0,3),(1,3),(2,3),(3,3),(0,7),(1,7).
  - gen_en is never multi-hot, and gen_en=0 for one cycle between slots.
- Backpressure: out_ready=0, FIFO_DEPTH=8.
  - After 8 pushes, level=8, the FSM sits in HOLD and gen_en=0.
  - Pulse out_ready for 1 cycle: level 7, then one GRANT, then level 8 again. No sample is lost or duplicated.
- Stop: deassert run on the 2nd cycle of the slot for idx=2.
  - Sample (2,3) is still pushed, then IDLE, busy=0, gen_en=0.
  - Reassert run: the next grant goes to idx=3 and captures 3.
- Wrap: SLOT_CYCLES=1, N_GEN=2, run for 600 cycles.
  - Captured data increments by 1 per source per round and wraps 255->0.
- Async reset: assert res low mid-GRANT, between clock edges.
  - gen_en=0, out_valid=0 and level=0 immediately.
  - After release with run=1, the first grant goes to idx=0.
- Simultaneous push/pop: with level=1, the pop and the end-of-slot push land in the same cycle. level stays 1 and order is preserved.
